counter_multi_ch: RTL and testbench

- Parametrised successor to the single-channel counter/FSM pair: N_CH independent up-counters, each driven by its own IDLE/RUN/DONE state machine.
- Each channel counts a latched number of cycles after a start request.
- Adds per-channel one-shot or auto-reload mode, per-channel abort, and an aggregate busy flag.
- Sits under the control block as a shared timer/count resource. All outputs are registered.

---
 rtl/counter_multi_ch.sv | 115 +++++++++++
 tb/tb_counter_multi_ch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_multi_ch.sv
// Purpose: N_CH independent up-counters, each sequenced by its own IDLE/RUN/DONE state machine.
// Latency: start sampled at edge t gives run_o=1 and cnt=0 after edge t; done_o follows val cycles later.
// Backpressure: none; start is only accepted while IDLE, and stop aborts a channel in any state.
module counter_multi_ch #(
  parameter int CNT_WIDTH = 8,
  parameter int N_CH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           start_i,
  input  logic [N_CH-1:0]           stop_i,
  input  logic [N_CH-1:0]           reload_i,
  input  logic [N_CH*CNT_WIDTH-1:0] cnt_val_i,
  output logic [N_CH*CNT_WIDTH-1:0] cnt_o,
  output logic [N_CH-1:0]           idle_o,
  output logic [N_CH-1:0]           run_o,
  output logic [N_CH-1:0]           done_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               st_q  [N_CH];
  state_t               st_d  [N_CH];
  logic [CNT_WIDTH-1:0] cnt_q [N_CH];
  logic [CNT_WIDTH-1:0] cnt_d [N_CH];
  logic [CNT_WIDTH-1:0] val_q [N_CH];
  logic [CNT_WIDTH-1:0] val_d [N_CH];
  logic [N_CH-1:0]      mode_q, mode_d;
  logic [N_CH-1:0]      idle_d, run_d, done_d;

  // Per-channel next-state, count and latched-parameter logic; channels never interact.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      st_d[k]   = st_q[k];
      cnt_d[k]  = cnt_q[k];
      val_d[k]  = val_q[k];
      mode_d[k] = mode_q[k];
      case (st_q[k])
        S_IDLE: begin
          // Stop wins over a simultaneous start.
          if (start_i[k] && !stop_i[k]) begin
            val_d[k]  = cnt_val_i[k*CNT_WIDTH +: CNT_WIDTH];
            mode_d[k] = reload_i[k];
            cnt_d[k]  = '0;
            st_d[k]   = (cnt_val_i[k*CNT_WIDTH +: CNT_WIDTH] != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (stop_i[k]) begin
            st_d[k]  = S_IDLE;
            cnt_d[k] = '0;
          end else if (cnt_q[k] == val_q[k] - 1'b1) begin
            // Hold at val-1 so the count never exceeds the target.
            st_d[k] = S_DONE;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        S_DONE: begin
          if (stop_i[k]) begin
            st_d[k]  = S_IDLE;
            cnt_d[k] = '0;
          end else if (mode_q[k]) begin
            // Auto-reload; a zero target keeps re-entering DONE every cycle.
            cnt_d[k] = '0;
            st_d[k]  = (val_q[k] != '0) ? S_RUN : S_DONE;
          end else begin
            // One-shot: final count stays visible while idle.
            st_d[k] = S_IDLE;
          end
        end
        default: begin
          st_d[k]  = S_IDLE;
          cnt_d[k] = '0;
        end
      endcase
      idle_d[k] = (st_d[k] == S_IDLE);
      run_d[k]  = (st_d[k] == S_RUN);
      done_d[k] = (st_d[k] == S_DONE);
    end
  end

  // State registers and registered status flags, all decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        st_q[k]  <= S_IDLE;
        cnt_q[k] <= '0;
        val_q[k] <= '0;
      end
      mode_q <= '0;
      idle_o <= '1;
      run_o  <= '0;
      done_o <= '0;
      busy_o <= 1'b0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        st_q[k]  <= st_d[k];
        cnt_q[k] <= cnt_d[k];
        val_q[k] <= val_d[k];
      end
      mode_q <= mode_d;
      idle_o <= idle_d;
      run_o  <= run_d;
      done_o <= done_d;
      busy_o <= |(run_d | done_d);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
    assign cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

endmodule

// File: tb/tb_counter_multi_ch.sv
// Purpose: self-checking bench for counter_multi_ch (vector table, directed sequences, random vs schedule model).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; inputs driven with blocking assignments between edges.
module tb_counter_multi_ch;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   start_i, stop_i, reload_i;
  logic [N*W-1:0] cnt_val_i;
  logic [N*W-1:0] cnt_o;
  logic [N-1:0]   idle_o, run_o, done_o;
  logic           busy_o;

  int checks = 0;
  int errors = 0;

  counter_multi_ch #(.CNT_WIDTH(W), .N_CH(N)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .reload_i(reload_i),
    .cnt_val_i(cnt_val_i), .cnt_o(cnt_o), .idle_o(idle_o), .run_o(run_o),
    .done_o(done_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Schedule model: a started channel's phase is pure arithmetic on edges elapsed since its start.
  bit m_act  [N];
  int m_sedge[N];
  int m_val  [N];
  bit m_mode [N];
  int m_icnt [N];
  int edge_n = 0;

  // ph: 0 idle, 1 run, 2 done
  task automatic mstate(input int k, input int e, output int ph, output int c);
    int o;
    if (!m_act[k]) begin
      ph = 0; c = m_icnt[k];
    end else begin
      o = e - m_sedge[k];
      if (m_mode[k] && o > m_val[k]) o = o % (m_val[k] + 1);
      if (o < m_val[k]) begin
        ph = 1; c = o;
      end else if (o == m_val[k]) begin
        ph = 2; c = (m_val[k] == 0) ? 0 : m_val[k] - 1;
      end else begin
        ph = 0; c = (m_val[k] == 0) ? 0 : m_val[k] - 1;
      end
    end
  endtask

  task automatic model_edge();
    int ph, c;
    for (int k = 0; k < N; k++) begin
      mstate(k, edge_n - 1, ph, c);
      if (rst) begin
        m_act[k] = 0; m_icnt[k] = 0;
      end else if (ph == 0) begin
        if (start_i[k] && !stop_i[k]) begin
          m_act[k] = 1; m_sedge[k] = edge_n;
          m_val[k] = int'(cnt_val_i[k*W +: W]); m_mode[k] = reload_i[k];
        end
      end else if (stop_i[k]) begin
        m_act[k] = 0; m_icnt[k] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic compare_model();
    int ph, c;
    logic [N-1:0]   ei, er, ed;
    logic [N*W-1:0] ec;
    for (int k = 0; k < N; k++) begin
      mstate(k, edge_n, ph, c);
      ei[k] = (ph == 0); er[k] = (ph == 1); ed[k] = (ph == 2);
      ec[k*W +: W] = W'(c);
    end
    chk("model_idle", 64'(idle_o), 64'(ei));
    chk("model_run",  64'(run_o),  64'(er));
    chk("model_done", 64'(done_o), 64'(ed));
    chk("model_busy", 64'(busy_o), 64'(|(er | ed)));
    chk("model_cnt",  64'(cnt_o),  64'(ec));
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    rst = 0; start_i = '0; stop_i = '0; reload_i = '0; cnt_val_i = '0;
  endtask

  typedef struct {
    logic           rst;
    logic [N-1:0]   start, stop, reload;
    logic [N*W-1:0] val;
    logic [N-1:0]   e_idle, e_run, e_done;
    logic           e_busy;
    logic [N*W-1:0] e_cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Reset, then channel 0 one-shot with val=5.
    tbl[0] = '{1'b1, 4'h0, 4'h0, 4'h0, 32'h0, 4'hf, 4'h0, 4'h0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 4'h1, 4'h0, 4'h0, 32'h5, 4'he, 4'h1, 4'h0, 1'b1, 32'h0};
    tbl[2] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 4'he, 4'h1, 4'h0, 1'b1, 32'h1};
    tbl[3] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 4'he, 4'h1, 4'h0, 1'b1, 32'h2};
    tbl[4] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 4'he, 4'h1, 4'h0, 1'b1, 32'h3};
    tbl[5] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 4'he, 4'h1, 4'h0, 1'b1, 32'h4};
    tbl[6] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 4'he, 4'h0, 4'h1, 1'b1, 32'h4};
    tbl[7] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 4'hf, 4'h0, 4'h0, 1'b0, 32'h4};
    tbl[8] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 4'hf, 4'h0, 4'h0, 1'b0, 32'h4};

    idle_inputs();
    for (int k = 0; k < N; k++) begin
      m_act[k] = 0; m_icnt[k] = 0; m_sedge[k] = 0; m_val[k] = 0; m_mode[k] = 0;
    end

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; start_i = tbl[i].start; stop_i = tbl[i].stop;
      reload_i = tbl[i].reload; cnt_val_i = tbl[i].val;
      step();
      chk("tbl_idle", 64'(idle_o), 64'(tbl[i].e_idle));
      chk("tbl_run",  64'(run_o),  64'(tbl[i].e_run));
      chk("tbl_done", 64'(done_o), 64'(tbl[i].e_done));
      chk("tbl_busy", 64'(busy_o), 64'(tbl[i].e_busy));
      chk("tbl_cnt",  64'(cnt_o),  64'(tbl[i].e_cnt));
    end

    // ch1 val=3 auto-reload; stop during second RUN at cnt=1.
    idle_inputs();
    start_i = 4'b0010; reload_i = 4'b0010; cnt_val_i = 32'h0000_0300;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ch1_reload_seq", 64'({run_o[1], done_o[1], cnt_o[15:8]}),
          (i < 2) ? 64'({1'b1, 1'b0, 8'(i + 1)}) : 64'({1'b0, 1'b1, 8'd2}));
    end
    step();
    chk("ch1_rerun", 64'({run_o[1], cnt_o[15:8]}), 64'({1'b1, 8'd0}));
    step();
    chk("ch1_cnt1", 64'(cnt_o[15:8]), 64'd1);
    stop_i = 4'b0010;
    step();
    stop_i = '0;
    chk("ch1_stopped", 64'({idle_o[1], done_o[1], cnt_o[15:8]}), 64'({1'b1, 1'b0, 8'd0}));
    step();

    // ch2 val=0: one-shot single pulse, then reload stream until stop.
    start_i = 4'b0100;
    step();
    idle_inputs();
    chk("ch2_zero_done", 64'({done_o[2], run_o[2]}), 64'b10);
    step();
    chk("ch2_zero_idle", 64'(idle_o[2]), 64'd1);
    start_i = 4'b0100; reload_i = 4'b0100;
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ch2_stream", 64'(done_o[2]), 64'd1);
    end
    stop_i = 4'b0100;
    step();
    stop_i = '0;
    chk("ch2_stream_stop", 64'({idle_o[2], done_o[2]}), 64'b10);

    // ch0 val=2 and ch3 val=4 started together.
    start_i = 4'b1001; cnt_val_i = 32'h0400_0002;
    step();
    idle_inputs();
    chk("dual_busy_s", 64'(busy_o), 64'd1);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("dual_done0", 64'(done_o[0]), 64'(i == 2));
      chk("dual_done3", 64'(done_o[3]), 64'(i == 4));
      chk("dual_busy", 64'(busy_o), 64'(i <= 4));
    end

    // start+stop on an idle channel; restart during RUN is ignored.
    start_i = 4'b0010; stop_i = 4'b0010; cnt_val_i = 32'h0000_0300;
    step();
    idle_inputs();
    chk("start_stop_idle", 64'(idle_o[1]), 64'd1);
    start_i = 4'b0010; cnt_val_i = 32'h0000_0300;
    step();
    start_i = 4'b0010; cnt_val_i = 32'h0000_0900;
    step();
    idle_inputs();
    step();
    step();
    chk("restart_ignored", 64'({done_o[1], cnt_o[15:8]}), 64'({1'b1, 8'd2}));
    step();

    // Reset mid-count at cnt=100 of val=200.
    start_i = 4'b0001; cnt_val_i = 32'h0000_00c8;
    step();
    idle_inputs();
    for (int i = 0; i < 100; i++) step();
    chk("pre_rst_cnt", 64'(cnt_o[7:0]), 64'd100);
    rst = 1;
    step();
    rst = 0;
    chk("rst_mid", 64'({idle_o, done_o, busy_o, cnt_o}), 64'({4'hf, 4'h0, 1'b0, 32'h0}));

    // Random traffic against the schedule model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < N; k++) begin
        start_i[k]  = $urandom_range(0, 2) == 0;
        stop_i[k]   = $urandom_range(0, 15) == 0;
        reload_i[k] = $urandom_range(0, 1) == 1;
        cnt_val_i[k*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 40))
                                                           : W'($urandom_range(0, 6));
      end
      step();
    end
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
